// File: rtl/platform_reset_sequencer.sv
// Qualifies pl0_resetn and the clock-wizard lock, then releases NUM_STAGES
// downstream reset domains in order with fixed spacing; re-asserts on lock loss or software request.
module platform_reset_sequencer #(
    parameter int NUM_STAGES   = 4,
    parameter int STAGE_DELAY  = 16,
    parameter int LOCK_SETTLE  = 64,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  pl_clk0,
    input  logic                  pl0_resetn,
    input  logic                  clk_wiz_locked,
    input  logic                  sw_reset_req,
    output logic [NUM_STAGES-1:0] stage_resetn,
    output logic                  seq_done,
    output logic                  lock_timeout,
    output logic [7:0]            lock_lost_cnt,
    output logic [2:0]            seq_state
);

    localparam int REL_SPAN = NUM_STAGES * STAGE_DELAY;
    localparam int CNT_MAX_A = (LOCK_TIMEOUT > LOCK_SETTLE) ? LOCK_TIMEOUT : LOCK_SETTLE;
    localparam int CNT_MAX = (CNT_MAX_A > REL_SPAN) ? CNT_MAX_A : REL_SPAN;
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic [7:0]            lost_q, lost_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                  locked_s;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge pl_clk0) begin
        if (!pl0_resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_wiz_locked};
        end
    end

    always_ff @(posedge pl_clk0) begin
        if (!pl0_resetn) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            stage_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            lost_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            lost_q    <= lost_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        lost_d    = lost_q;

        if (sw_reset_req) begin
            state_d   = WAIT_LOCK;
            cnt_d     = '0;
            stage_d   = '0;
            done_d    = 1'b0;
            timeout_d = 1'b0;
        end else if (!locked_s && (state_q == RELEASE || state_q == RUN)) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            stage_d = '0;
            done_d  = 1'b0;
            lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        state_d   = FAULT;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SETTLE: begin
                    if (!locked_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_SETTLE - 1)) begin
                        cnt_d   = '0;
                        stage_d = NUM_STAGES'(1);
                        if (NUM_STAGES == 1) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    // Counter restarts at each release, so stage i lands i*STAGE_DELAY after stage 0.
                    if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
                        cnt_d   = '0;
                        stage_d = (stage_q << 1) | NUM_STAGES'(1);
                        if (stage_d[NUM_STAGES-1]) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                end
                FAULT: begin
                    if (locked_s) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    stage_d = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    assign stage_resetn  = stage_q;
    assign seq_done      = done_q;
    assign lock_timeout  = timeout_q;
    assign lock_lost_cnt = lost_q;
    assign seq_state     = state_q;

endmodule

// File: tb/tb_platform_reset_sequencer.sv
// Directed bench for platform_reset_sequencer: bring-up timing, lock glitches,
// lock loss, timeout, request/loss priority, counter saturation and mid-sequence reset.
module tb_platform_reset_sequencer;

    logic       pl_clk0;
    logic       pl0_resetn;
    logic       clk_wiz_locked;
    logic       sw_reset_req;
    logic [3:0] stage_resetn;
    logic       seq_done;
    logic       lock_timeout;
    logic [7:0] lock_lost_cnt;
    logic [2:0] seq_state;

    int checks = 0;
    int errors = 0;
    int exp_lost = 0;

    platform_reset_sequencer dut (
        .pl_clk0        (pl_clk0),
        .pl0_resetn     (pl0_resetn),
        .clk_wiz_locked (clk_wiz_locked),
        .sw_reset_req   (sw_reset_req),
        .stage_resetn   (stage_resetn),
        .seq_done       (seq_done),
        .lock_timeout   (lock_timeout),
        .lock_lost_cnt  (lock_lost_cnt),
        .seq_state      (seq_state)
    );

    initial pl_clk0 = 1'b0;
    always #5 pl_clk0 = ~pl_clk0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge pl_clk0);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max_cycles, input string tag);
        int n;
        n = 0;
        while (seq_state !== s && n < max_cycles) begin
            step(1);
            n++;
        end
        check_eq(tag, {29'd0, seq_state}, {29'd0, s});
    endtask

    // Lock is first sampled on the next edge E0; stage 0 at E0+66, then every 16.
    task automatic bringup(input string tag);
        clk_wiz_locked = 1'b1;
        step(3);
        check_eq({tag, "_settle"}, {29'd0, seq_state}, 32'd1);
        step(63);
        check_eq({tag, "_no_early"}, {28'd0, stage_resetn}, 32'h0);
        step(1);
        check_eq({tag, "_stage0"}, {28'd0, stage_resetn}, 32'h1);
        check_eq({tag, "_release"}, {29'd0, seq_state}, 32'd2);
        step(15);
        check_eq({tag, "_pre1"}, {28'd0, stage_resetn}, 32'h1);
        step(1);
        check_eq({tag, "_stage1"}, {28'd0, stage_resetn}, 32'h3);
        step(16);
        check_eq({tag, "_stage2"}, {28'd0, stage_resetn}, 32'h7);
        step(15);
        check_eq({tag, "_pre3"}, {28'd0, stage_resetn}, 32'h7);
        check_eq({tag, "_pre_done"}, {31'd0, seq_done}, 32'd0);
        step(1);
        check_eq({tag, "_stage3"}, {28'd0, stage_resetn}, 32'hF);
        check_eq({tag, "_done"}, {31'd0, seq_done}, 32'd1);
        check_eq({tag, "_run"}, {29'd0, seq_state}, 32'd3);
    endtask

    task automatic lose_lock_in_run(input string tag);
        clk_wiz_locked = 1'b0;
        step(2);
        check_eq({tag, "_hold"}, {28'd0, stage_resetn}, 32'hF);
        step(1);
        exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
        check_eq({tag, "_stages"}, {28'd0, stage_resetn}, 32'h0);
        check_eq({tag, "_done"}, {31'd0, seq_done}, 32'd0);
        check_eq({tag, "_state"}, {29'd0, seq_state}, 32'd0);
        check_eq({tag, "_lost"}, {24'd0, lock_lost_cnt}, exp_lost);
    endtask

    initial begin
        pl0_resetn     = 1'b0;
        clk_wiz_locked = 1'b0;
        sw_reset_req   = 1'b0;
        step(3);
        check_eq("rst_stages", {28'd0, stage_resetn}, 32'h0);
        check_eq("rst_done", {31'd0, seq_done}, 32'd0);
        check_eq("rst_timeout", {31'd0, lock_timeout}, 32'd0);
        check_eq("rst_lost", {24'd0, lock_lost_cnt}, 32'd0);
        check_eq("rst_state", {29'd0, seq_state}, 32'd0);

        pl0_resetn = 1'b1;
        bringup("nominal");

        lose_lock_in_run("loss_run");
        bringup("relock");
        lose_lock_in_run("loss_run2");

        // Glitch: lock drops for 5 sampled cycles at settle count 30.
        clk_wiz_locked = 1'b1;
        step(3);
        check_eq("glitch_settle", {29'd0, seq_state}, 32'd1);
        step(30);
        clk_wiz_locked = 1'b0;
        step(5);
        check_eq("glitch_state", {29'd0, seq_state}, 32'd0);
        check_eq("glitch_stages", {28'd0, stage_resetn}, 32'h0);
        check_eq("glitch_lost", {24'd0, lock_lost_cnt}, exp_lost);
        bringup("glitch_relock");

        // Request and lock loss arrive together in RELEASE after stage 1.
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        check_eq("sw_from_run", {28'd0, stage_resetn}, 32'h0);
        clk_wiz_locked = 1'b0;
        step(4);
        clk_wiz_locked = 1'b1;
        step(83);
        check_eq("simul_stage1", {28'd0, stage_resetn}, 32'h3);
        check_eq("simul_release", {29'd0, seq_state}, 32'd2);
        clk_wiz_locked = 1'b0;
        step(2);
        check_eq("simul_pre", {28'd0, stage_resetn}, 32'h3);
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        check_eq("simul_stages", {28'd0, stage_resetn}, 32'h0);
        check_eq("simul_state", {29'd0, seq_state}, 32'd0);
        check_eq("simul_lost", {24'd0, lock_lost_cnt}, exp_lost);

        // Timeout: WAIT_LOCK counter was cleared on the request edge.
        step(4095);
        check_eq("to_pre_state", {29'd0, seq_state}, 32'd0);
        check_eq("to_pre_flag", {31'd0, lock_timeout}, 32'd0);
        step(1);
        check_eq("to_state", {29'd0, seq_state}, 32'd4);
        check_eq("to_flag", {31'd0, lock_timeout}, 32'd1);
        check_eq("to_stages", {28'd0, stage_resetn}, 32'h0);
        bringup("fault_relock");
        check_eq("to_sticky", {31'd0, lock_timeout}, 32'd1);
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        check_eq("to_clear", {31'd0, lock_timeout}, 32'd0);
        check_eq("to_clear_state", {29'd0, seq_state}, 32'd0);
        check_eq("to_clear_stages", {28'd0, stage_resetn}, 32'h0);
        check_eq("to_clear_lost", {24'd0, lock_lost_cnt}, exp_lost);
        step(1);
        check_eq("to_restart", {29'd0, seq_state}, 32'd1);

        // Saturation: 260 losses, each right after stage 0 releases.
        for (int i = 0; i < 260; i++) begin
            wait_state(3'd2, 200, "sat_release");
            clk_wiz_locked = 1'b0;
            wait_state(3'd0, 10, "sat_wait");
            clk_wiz_locked = 1'b1;
            exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
            check_eq("sat_lost", {24'd0, lock_lost_cnt}, exp_lost);
        end
        check_eq("sat_final", {24'd0, lock_lost_cnt}, 32'd255);

        // Reset in the middle of RELEASE.
        wait_state(3'd2, 200, "mid_release");
        step(3);
        check_eq("mid_stage0", {28'd0, stage_resetn}, 32'h1);
        pl0_resetn = 1'b0;
        step(1);
        check_eq("mid_rst_stages", {28'd0, stage_resetn}, 32'h0);
        check_eq("mid_rst_done", {31'd0, seq_done}, 32'd0);
        check_eq("mid_rst_lost", {24'd0, lock_lost_cnt}, 32'd0);
        check_eq("mid_rst_timeout", {31'd0, lock_timeout}, 32'd0);
        check_eq("mid_rst_state", {29'd0, seq_state}, 32'd0);
        clk_wiz_locked = 1'b0;
        step(2);
        pl0_resetn = 1'b1;
        exp_lost = 0;
        bringup("post_reset");
        check_eq("post_reset_lost", {24'd0, lock_lost_cnt}, exp_lost);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
